// File: rtl/input_processor.sv
// Request capture for the elevator controller: synchronizes switches and buttons,
// latches cabin / hall-up / hall-down requests and clears requests served by a stop.
module input_processor (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       btnc,
    input  logic       btnu,
    input  logic       btnd,
    input  logic [2:0] floor,
    input  logic [3:0] status,
    input  logic       nextup,
    input  logic       nextdown,
    output logic [7:0] up,
    output logic [7:0] down,
    output logic [7:0] elevator_btn
);

    localparam logic [3:0] STATUS_STOPPED = 4'd7;
    // Floor 8 cannot call up and floor 1 cannot call down.
    localparam logic [7:0] UP_ALLOWED     = 8'b0111_1111;
    localparam logic [7:0] DOWN_ALLOWED   = 8'b1111_1110;

    localparam int BTN_CAB  = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_DOWN = 2;

    function automatic logic [7:0] floor_onehot(input logic [2:0] f);
        floor_onehot = 8'h01 << f;
    endfunction

    logic [2:0] btn_s1_r;
    logic [2:0] btn_s2_r;
    logic [2:0] btn_prev_r;
    logic [7:0] sw_s1_r;
    logic [7:0] sw_s2_r;

    logic [2:0] pulse_s;
    logic [7:0] set_cab_s;
    logic [7:0] set_up_s;
    logic [7:0] set_down_s;
    logic [7:0] clr_cab_s;
    logic [7:0] clr_up_s;
    logic [7:0] clr_down_s;
    logic [7:0] cab_next_s;
    logic [7:0] up_next_s;
    logic [7:0] down_next_s;

    logic [7:0] cab_r;
    logic [7:0] up_r;
    logic [7:0] down_r;

    // Two-flop synchronizers for buttons and switches, plus the button edge-history flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1_r   <= 3'b000;
            btn_s2_r   <= 3'b000;
            btn_prev_r <= 3'b000;
            sw_s1_r    <= 8'h00;
            sw_s2_r    <= 8'h00;
        end else begin
            btn_s1_r   <= {btnd, btnu, btnc};
            btn_s2_r   <= btn_s1_r;
            btn_prev_r <= btn_s2_r;
            sw_s1_r    <= sw;
            sw_s2_r    <= sw_s1_r;
        end
    end

    // Press pulses and the per-direction set masks they produce.
    always_comb begin
        pulse_s    = btn_s2_r & ~btn_prev_r;
        set_cab_s  = 8'h00;
        set_up_s   = 8'h00;
        set_down_s = 8'h00;
        if (pulse_s[BTN_CAB]) begin
            set_cab_s = sw_s2_r;
        end else begin
            set_cab_s = 8'h00;
        end
        if (pulse_s[BTN_UP]) begin
            set_up_s = sw_s2_r & UP_ALLOWED;
        end else begin
            set_up_s = 8'h00;
        end
        if (pulse_s[BTN_DOWN]) begin
            set_down_s = sw_s2_r & DOWN_ALLOWED;
        end else begin
            set_down_s = 8'h00;
        end
    end

    // Clear masks for the floor being served; direction decides which hall call is answered.
    always_comb begin
        clr_cab_s  = 8'h00;
        clr_up_s   = 8'h00;
        clr_down_s = 8'h00;
        if (status == STATUS_STOPPED) begin
            clr_cab_s = floor_onehot(floor);
            case ({nextup, nextdown})
                2'b10:   clr_up_s   = floor_onehot(floor);
                2'b01:   clr_down_s = floor_onehot(floor);
                2'b00,
                2'b11: begin
                    clr_up_s   = floor_onehot(floor);
                    clr_down_s = floor_onehot(floor);
                end
                default: begin
                    clr_up_s   = floor_onehot(floor);
                    clr_down_s = floor_onehot(floor);
                end
            endcase
        end else begin
            clr_cab_s  = 8'h00;
            clr_up_s   = 8'h00;
            clr_down_s = 8'h00;
        end
    end

    // Clear is applied after set so a request arriving at the floor being served is dropped.
    always_comb begin
        cab_next_s  = (cab_r  | set_cab_s)  & ~clr_cab_s;
        up_next_s   = (up_r   | set_up_s)   & ~clr_up_s   & UP_ALLOWED;
        down_next_s = (down_r | set_down_s) & ~clr_down_s & DOWN_ALLOWED;
    end

    // Sticky request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cab_r  <= 8'h00;
            up_r   <= 8'h00;
            down_r <= 8'h00;
        end else begin
            cab_r  <= cab_next_s;
            up_r   <= up_next_s;
            down_r <= down_next_s;
        end
    end

    assign elevator_btn = cab_r;
    assign up           = up_r;
    assign down         = down_r;

endmodule

// File: tb/tb_input_processor.sv
// Self-checking bench for input_processor: directed scenarios plus randomized presses
// and stops compared against a per-floor request model.
module tb_input_processor;

    logic       clk;
    logic       rst;
    logic [7:0] sw;
    logic       btnc;
    logic       btnu;
    logic       btnd;
    logic [2:0] floor;
    logic [3:0] status;
    logic       nextup;
    logic       nextdown;
    logic [7:0] up;
    logic [7:0] down;
    logic [7:0] elevator_btn;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_up;
    logic [7:0] exp_dn;
    logic [7:0] exp_cab;

    input_processor dut (
        .clk          (clk),
        .rst          (rst),
        .sw           (sw),
        .btnc         (btnc),
        .btnu         (btnu),
        .btnd         (btnd),
        .floor        (floor),
        .status       (status),
        .nextup       (nextup),
        .nextdown     (nextdown),
        .up           (up),
        .down         (down),
        .elevator_btn (elevator_btn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a stop at a floor serves that floor's cabin request and the hall call(s)
    // in the direction the car will leave (both when idle or ambiguous).
    task automatic model_serve();
        if (status == 4'd7) begin
            exp_cab[floor] = 1'b0;
            if (nextup && !nextdown) exp_up[floor] = 1'b0;
            else if (nextdown && !nextup) exp_dn[floor] = 1'b0;
            else begin
                exp_up[floor] = 1'b0;
                exp_dn[floor] = 1'b0;
            end
        end
    endtask

    // Model: a press of a button registers each selected floor that can take that request.
    task automatic model_press(input int kind, input logic [7:0] v);
        for (int f = 0; f < 8; f++) begin
            if (v[f]) begin
                if (kind == 0) exp_cab[f] = 1'b1;
                else if (kind == 1 && f != 7) exp_up[f] = 1'b1;
                else if (kind == 2 && f != 0) exp_dn[f] = 1'b1;
            end
        end
        model_serve();
    endtask

    // Stimulus: settle sw, press one button for 'hold' cycles, release and let it propagate.
    task automatic press(input int kind, input logic [7:0] v, input int hold);
        @(negedge clk);
        sw = v;
        repeat (3) @(negedge clk);
        if (kind == 0) btnc = 1'b1;
        else if (kind == 1) btnu = 1'b1;
        else btnd = 1'b1;
        repeat (hold) @(negedge clk);
        btnc = 1'b0;
        btnu = 1'b0;
        btnd = 1'b0;
        repeat (4) @(negedge clk);
        model_press(kind, v);
    endtask

    function automatic logic [3:0] idle_status();
        logic [3:0] s;
        s = 4'($urandom_range(0, 15));
        if (s == 4'd7) s = 4'd0;
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({up, down, elevator_btn} !== 24'h000000) begin
            errors++;
            $display("FAIL reset_hold: got %h expected 000000", {up, down, elevator_btn});
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({up, down, elevator_btn} !== 24'h000000) begin
            errors++;
            $display("FAIL reset_release: got %h expected 000000", {up, down, elevator_btn});
        end
    endtask

    task automatic test_cabin();
        @(negedge clk);
        sw = 8'b1001_1000;
        repeat (3) @(negedge clk);
        btnc = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (e < 2 && elevator_btn !== 8'h00) begin
                errors++;
                $display("FAIL cabin_latency_early edge%0d: got %h expected 00", e, elevator_btn);
            end else if (e == 2 && elevator_btn !== 8'h98) begin
                errors++;
                $display("FAIL cabin_latency_edge3: got %h expected 98", elevator_btn);
            end
        end
        repeat (6) @(negedge clk);
        btnc = 1'b0;
        repeat (3) @(negedge clk);
        model_press(0, 8'b1001_1000);
        checks++;
        if ({up, down, elevator_btn} !== {exp_up, exp_dn, exp_cab} || elevator_btn !== 8'h98) begin
            errors++;
            $display("FAIL cabin_held: got %h expected 000098", {up, down, elevator_btn});
        end
    endtask

    task automatic test_hall();
        press(1, 8'b0100_1000, 1);
        checks++;
        if (up !== 8'h48) begin
            errors++;
            $display("FAIL hall_up_first: got %h expected 48", up);
        end
        press(1, 8'b0000_1100, 2);
        checks++;
        if (up !== 8'h4C) begin
            errors++;
            $display("FAIL hall_up_second: got %h expected 4c", up);
        end
        press(2, 8'b0000_1100, 1);
        checks++;
        if (down !== 8'h0C || {up, down, elevator_btn} !== {exp_up, exp_dn, exp_cab}) begin
            errors++;
            $display("FAIL hall_down: got %h expected %h", {up, down, elevator_btn},
                     {exp_up, exp_dn, exp_cab});
        end
    endtask

    task automatic test_directional_clear();
        @(negedge clk);
        floor = 3'd3;
        nextup = 1'b1;
        nextdown = 1'b0;
        status = 4'd7;
        @(posedge clk);
        #1;
        checks++;
        if ({up, down, elevator_btn} !== {8'h44, 8'h0C, 8'h90}) begin
            errors++;
            $display("FAIL dir_clear: got %h expected 440c90", {up, down, elevator_btn});
        end
        model_serve();
        @(negedge clk);
        status = 4'd1;
        repeat (4) @(negedge clk);
        checks++;
        if ({up, down, elevator_btn} !== {exp_up, exp_dn, exp_cab}) begin
            errors++;
            $display("FAIL dir_clear_hold: got %h expected %h", {up, down, elevator_btn},
                     {exp_up, exp_dn, exp_cab});
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        floor = 3'd2;
        nextup = 1'b0;
        nextdown = 1'b0;
        status = 4'd7;
        press(0, 8'h04, 2);
        checks++;
        if (elevator_btn[2] !== 1'b0 || {up, down, elevator_btn} !== {exp_up, exp_dn, exp_cab}) begin
            errors++;
            $display("FAIL collision_same: got %h expected %h", {up, down, elevator_btn},
                     {exp_up, exp_dn, exp_cab});
        end
        press(0, 8'h05, 1);
        checks++;
        if (elevator_btn !== 8'h91) begin
            errors++;
            $display("FAIL collision_other: got %h expected 91", elevator_btn);
        end
        @(negedge clk);
        status = 4'd0;
    endtask

    task automatic test_masking();
        press(1, 8'hFF, 1);
        checks++;
        if (up[7] !== 1'b0 || up !== exp_up) begin
            errors++;
            $display("FAIL mask_up: got %h expected %h", up, exp_up);
        end
        press(2, 8'hFF, 3);
        checks++;
        if (down[0] !== 1'b0 || down !== exp_dn) begin
            errors++;
            $display("FAIL mask_down: got %h expected %h", down, exp_dn);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int op;
            op = int'($urandom_range(0, 3));
            @(negedge clk);
            floor = 3'($urandom_range(0, 7));
            nextup = 1'($urandom_range(0, 1));
            nextdown = 1'($urandom_range(0, 1));
            if (op == 3) begin
                status = 4'd7;
                @(posedge clk);
                #1;
                model_serve();
                @(negedge clk);
                status = idle_status();
            end else begin
                status = ($urandom_range(0, 3) == 0) ? 4'd7 : idle_status();
                press(op, 8'($urandom), int'($urandom_range(1, 4)));
                @(negedge clk);
                status = idle_status();
            end
            @(negedge clk);
            checks++;
            if ({up, down, elevator_btn} !== {exp_up, exp_dn, exp_cab}) begin
                errors++;
                $display("FAIL random_op%0d iter%0d: got %h expected %h", op, i,
                         {up, down, elevator_btn}, {exp_up, exp_dn, exp_cab});
            end
        end
    endtask

    task automatic test_async_reset();
        press(0, 8'h3C, 1);
        press(1, 8'h21, 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({up, down, elevator_btn} !== 24'h000000) begin
            errors++;
            $display("FAIL async_reset: got %h expected 000000", {up, down, elevator_btn});
        end
        exp_up = 8'h00;
        exp_dn = 8'h00;
        exp_cab = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({up, down, elevator_btn} !== 24'h000000) begin
            errors++;
            $display("FAIL async_reset_release: got %h expected 000000", {up, down, elevator_btn});
        end
    endtask

    initial begin
        rst = 1'b0;
        sw = 8'h00;
        btnc = 1'b0;
        btnu = 1'b0;
        btnd = 1'b0;
        floor = 3'd0;
        status = 4'd0;
        nextup = 1'b0;
        nextdown = 1'b0;
        exp_up = 8'h00;
        exp_dn = 8'h00;
        exp_cab = 8'h00;
        test_reset();
        test_cabin();
        test_hall();
        test_directional_clear();
        test_collision();
        test_masking();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
